soc_system_sprite_line_fetch: RTL and testbench
===============================================

// Module: soc_system_sprite_line_fetch
// PURPOSE
//   Downstream consumer of the 1024x16 single-port sprite on-chip memory (32x32 sprite, 16-bit pixels).
//   Per scanline, prefetches one 32-word sprite row into a ping-pong line buffer.
//   Serves pixels to the VGA pipeline against hcount; the memory port is read-only from this block.
// PARAMETERS
//   SPRITE_W   32       sprite width in pixels = words per row; power of 2
//   SPRITE_H   32       sprite height in rows; SPRITE_W*SPRITE_H <= 2**ADDR_W
//   ADDR_W     10       memory address width
//   DATA_W     16       pixel/word width
//   KEY_COLOR  16'h0000 transparent colour; matching pixels are reported invalid
// PORTS
//   clk            in   1       system clock (also drives the memory)
//   reset_n        in   1       reset; synchronous, active-low
//   line_start     in   1       1-cycle pulse: swap buffers, begin fetch for line_num
//   line_num       in   10      screen line that the fetch targets (displayed after next line_start)
//   sprite_x       in   10      sprite left edge; latched with line_start for the fetched row
//   sprite_y       in   10      sprite top edge; sampled with line_start
//   fetch_busy     out  1       high from the cycle after line_start until the fetch completes
//   fetch_done     out  1       1-cycle pulse when the fill buffer is complete
//   rom_address    out  ADDR_W  memory address
//   rom_chipselect out  1       high while a read is issued
//   rom_clken      out  1       memory clock enable; high in FETCH/DRAIN
//   rom_readdata   in   DATA_W  memory q; valid 1 cycle after rom_address
//   hcount         in   10      current display column
//   pix_valid      out  1       pixel opaque and inside sprite
//   pix_data       out  DATA_W  pixel colour; 0 when pix_valid=0
// BEHAVIOUR
//   - Reset (reset_n=0 at clk edge): state=IDLE; fetch_busy, fetch_done, rom_chipselect, rom_clken,
//     pix_valid = 0; rom_address = 0; pix_data = 0; both buffers marked empty; display select = 0.
//   - State machine: IDLE -> CHECK -> FETCH -> DRAIN -> IDLE.
//   - line_start (any state): toggle display select; new display buffer keeps its latched x and empty flag.
//     Latch sprite_x; enter CHECK.
//   - CHECK (1 cycle): row = {1'b0,line_num} - {1'b0,sprite_y}, 11-bit.
//     row in [0,SPRITE_H-1] -> FETCH with i=0.
//     Otherwise -> mark fill buffer empty, pulse fetch_done, return to IDLE.
//   - FETCH (SPRITE_W cycles): rom_address = row*SPRITE_W + i; i increments every cycle.
//     Word returned one cycle later is written to fill_buf[i_d], where i_d is i delayed one cycle.
//   - DRAIN (1 cycle): capture the last word; mark buffer non-empty; pulse fetch_done; go to IDLE.
//   - Latency: fetch_done is 34 cycles after line_start (CHECK 1 + FETCH 32 + DRAIN 1, default params).
//   - line_start during CHECK/FETCH/DRAIN: abort the fetch; no fetch_done for the aborted fetch.
//     The partially filled buffer is marked empty before the swap. Restart at CHECK next cycle.
//   - Display path, 1-cycle registered: col = {1'b0,hcount} - {1'b0,x_latched}, 11-bit.
//     pix_valid = col < SPRITE_W && buffer non-empty && word != KEY_COLOR.
//   - Wrap: col is negative when hcount < x_latched (MSB set); this is out of range, no wrap-around.
//   - Edge cases: sprite partly off the bottom of the screen is handled by the row range test.
//     sprite_y > line_num gives a negative row, treated as out of range.
//   - The memory is never written: the block drives no write or byteenable to it.
// CONFIGURATION
//   SPRITE_FETCH_HFLIP_EN defined: adds input hflip (1 bit), latched with line_start alongside sprite_x.
//     When the latched hflip = 1, the display read index is SPRITE_W-1-col.
//   Undefined: no hflip port; read index = col.
// TESTING
//   1. Reset, memory word n = n, sprite_y=100, sprite_x=200, pulse line_start with line_num=105.
//      -> addresses 160..191 issued on consecutive cycles; fetch_done 34 cycles later.
//   2. After test 1, pulse line_start, sweep hcount 0..639.
//      -> pix_valid only for hcount 200..231; pix_data=160+(hcount-200), 1 cycle after hcount.
//   3. line_num=99 and line_num=132 with sprite_y=100 -> no rom_chipselect.
//      -> fetch_done 1 cycle after CHECK; pix_valid=0 all line.
//   4. Word 165 = KEY_COLOR -> pix_valid=0 and pix_data=0 at hcount=205 only.
//   5. line_start again 10 cycles into FETCH -> fetch restarts at row base; aborted buffer displays nothing.
//   6. reset_n=0 mid-FETCH for 1 cycle -> all outputs 0 next cycle; IDLE; no fetch_done.
//      With SPRITE_FETCH_HFLIP_EN and hflip=1, test 2 gives pix_data=191-(hcount-200).

Source files
------------

// File: rtl/soc_system_sprite_line_fetch.sv
// Sprite line fetcher: per scanline, copies one sprite row from the single-port sprite memory
// into a ping-pong line buffer, then serves pixels against hcount from the other half.
// Optional feature macro: SPRITE_FETCH_HFLIP_EN adds the hflip input (horizontal mirror).
module soc_system_sprite_line_fetch #(
    parameter int unsigned SPRITE_W = 32,
    parameter int unsigned SPRITE_H = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter logic [DATA_W-1:0] KEY_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [9:0]        line_num,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
`ifdef SPRITE_FETCH_HFLIP_EN
    input  logic              hflip,
`endif
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    input  logic [DATA_W-1:0] rom_readdata,
    input  logic [9:0]        hcount,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data
);

    localparam int unsigned IDX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

    typedef enum logic [1:0] {StIdle, StCheck, StFetch, StDrain} state_e;

    state_e state_q, state_d;

    // Fetch bookkeeping
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_pend_q, wr_pend_d;
    logic [10:0]      row_q, row_d;
    logic             done_q, done_d;

    // Per-half buffer state; the fill half is always the one not being displayed
    logic             disp_sel_q, disp_sel_d;
    logic [1:0]       full_q, full_d;
    logic [1:0][9:0]  x_q, x_d;
`ifdef SPRITE_FETCH_HFLIP_EN
    logic [1:0]       hflip_q, hflip_d;
`endif
    logic [DATA_W-1:0] buf_q [2][SPRITE_W];

    // Display pipeline
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;

    logic              fill_sel;
    logic              row_in_range;
    logic              last_word;
    logic [ADDR_W-1:0] fetch_addr;
    logic [9:0]        x_disp;
    logic [10:0]       col;
    logic              col_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign fill_sel     = ~disp_sel_q;
    // A negative row (sprite_y > line_num) has bit 10 set and fails both terms
    assign row_in_range = !row_q[10] && (row_q < 11'(SPRITE_H));
    assign last_word    = (i_q == IDX_W'(SPRITE_W - 1));
    assign fetch_addr   = (ADDR_W'(row_q) << IDX_W) + ADDR_W'(i_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; line_start restarts from CHECK in any state
    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = StCheck;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StCheck: state_d = row_in_range ? StFetch : StIdle;
                StFetch: state_d = last_word ? StDrain : StFetch;
                StDrain: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: memory interface and busy flag decode straight from state
    always_comb begin
        fetch_busy     = (state_q != StIdle);
        rom_chipselect = (state_q == StFetch);
        rom_clken      = (state_q == StFetch) || (state_q == StDrain);
        rom_address    = (state_q == StFetch) ? fetch_addr : '0;
    end

    // Fetch datapath next state: counters, buffer flags, swap on line_start
    always_comb begin
        i_d        = i_q;
        wr_idx_d   = i_q;
        wr_pend_d  = 1'b0;
        row_d      = row_q;
        done_d     = 1'b0;
        disp_sel_d = disp_sel_q;
        full_d     = full_q;
        x_d        = x_q;
`ifdef SPRITE_FETCH_HFLIP_EN
        hflip_d    = hflip_q;
`endif

        case (state_q)
            StCheck: begin
                i_d = '0;
                if (!row_in_range) begin
                    full_d[fill_sel] = 1'b0;
                    done_d           = 1'b1;
                end
            end
            StFetch: begin
                // Word for address i returns next cycle and lands at wr_idx
                i_d       = i_q + 1'b1;
                wr_pend_d = 1'b1;
            end
            StDrain: begin
                full_d[fill_sel] = 1'b1;
                done_d           = 1'b1;
            end
            default: ;
        endcase

        if (line_start) begin
            // Abort: the partial buffer must not be shown once it becomes the display half
            if (state_q != StIdle) begin
                full_d[fill_sel] = 1'b0;
            end
            done_d     = 1'b0;
            wr_pend_d  = 1'b0;
            disp_sel_d = ~disp_sel_q;
            // The old display half becomes the new fill half
            x_d[disp_sel_q] = sprite_x;
`ifdef SPRITE_FETCH_HFLIP_EN
            hflip_d[disp_sel_q] = hflip;
`endif
            row_d = {1'b0, line_num} - {1'b0, sprite_y};
        end
    end

    // Fetch datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_q        <= '0;
            wr_idx_q   <= '0;
            wr_pend_q  <= 1'b0;
            row_q      <= '0;
            done_q     <= 1'b0;
            disp_sel_q <= 1'b0;
            full_q     <= '0;
            x_q        <= '0;
`ifdef SPRITE_FETCH_HFLIP_EN
            hflip_q    <= '0;
`endif
        end else begin
            i_q        <= i_d;
            wr_idx_q   <= wr_idx_d;
            wr_pend_q  <= wr_pend_d;
            row_q      <= row_d;
            done_q     <= done_d;
            disp_sel_q <= disp_sel_d;
            full_q     <= full_d;
            x_q        <= x_d;
`ifdef SPRITE_FETCH_HFLIP_EN
            hflip_q    <= hflip_d;
`endif
        end
    end

    // Line buffer storage; contents are qualified by full_q so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            buf_q[fill_sel][wr_idx_q] <= rom_readdata;
        end
    end

    // Display lookup: column relative to the latched sprite edge, no wrap-around
    always_comb begin
        x_disp       = x_q[disp_sel_q];
        col          = {1'b0, hcount} - {1'b0, x_disp};
        col_in_range = (col < 11'(SPRITE_W));
`ifdef SPRITE_FETCH_HFLIP_EN
        rd_idx = hflip_q[disp_sel_q] ? (IDX_W'(SPRITE_W - 1) - col[IDX_W-1:0])
                                     : col[IDX_W-1:0];
`else
        rd_idx = col[IDX_W-1:0];
`endif
        rd_word     = buf_q[disp_sel_q][rd_idx];
        pix_valid_d = col_in_range && full_q[disp_sel_q] && (rd_word != KEY_COLOR);
        pix_data_d  = pix_valid_d ? rd_word : '0;
    end

    // Display output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign fetch_done = done_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_soc_system_sprite_line_fetch.sv
// Directed bench for soc_system_sprite_line_fetch with a behavioural sprite memory.
// Honours SPRITE_FETCH_HFLIP_EN: when defined, hflip is driven high and mirrored expectations apply.
module tb_soc_system_sprite_line_fetch;

    localparam int W = 32;
`ifdef SPRITE_FETCH_HFLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        line_start;
    logic [9:0]  line_num;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        fetch_busy;
    logic        fetch_done;
    logic [9:0]  rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [15:0] rom_readdata = '0;
    logic [9:0]  hcount;
    logic        pix_valid;
    logic [15:0] pix_data;
`ifdef SPRITE_FETCH_HFLIP_EN
    logic        hflip;
`endif

    logic [15:0] mem [1024];

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int h;
        bit v;
        int d;
    } vec_t;
    vec_t vt[10];

    always #5 clk = ~clk;

    // Single-port memory: q valid one cycle after the address
    always @(posedge clk) begin
        if (rom_clken) rom_readdata <= mem[rom_address];
    end

    soc_system_sprite_line_fetch dut (
        .clk(clk),
        .reset_n(reset_n),
        .line_start(line_start),
        .line_num(line_num),
        .sprite_x(sprite_x),
        .sprite_y(sprite_y),
`ifdef SPRITE_FETCH_HFLIP_EN
        .hflip(hflip),
`endif
        .fetch_busy(fetch_busy),
        .fetch_done(fetch_done),
        .rom_address(rom_address),
        .rom_chipselect(rom_chipselect),
        .rom_clken(rom_clken),
        .rom_readdata(rom_readdata),
        .hcount(hcount),
        .pix_valid(pix_valid),
        .pix_data(pix_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int ln);
        line_num = 10'(ln);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Ticks until fetch_done or budget; returns ticks taken
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!fetch_done && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    // Expected {pix_valid, pix_data} for a sprite row starting at word `base`
    function automatic logic [16:0] model(input int h, input int x, input int base);
        int col;
        int idx;
        logic [15:0] word;
        col = h - x;
        if (col < 0 || col >= W) return '0;
        idx = FLIP ? (W - 1 - col) : col;
        word = mem[base + idx];
        if (word == 16'h0000) return '0;
        return {1'b1, word};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;
        int key_h;

        vt[0] = '{h: 0,    v: 1'b0, d: 0};
        vt[1] = '{h: 199,  v: 1'b0, d: 0};
        vt[2] = '{h: 200,  v: 1'b1, d: FLIP ? 191 : 160};
        vt[3] = '{h: 201,  v: 1'b1, d: FLIP ? 190 : 161};
        vt[4] = '{h: 215,  v: 1'b1, d: FLIP ? 176 : 175};
        vt[5] = '{h: 230,  v: 1'b1, d: FLIP ? 161 : 190};
        vt[6] = '{h: 231,  v: 1'b1, d: FLIP ? 160 : 191};
        vt[7] = '{h: 232,  v: 1'b0, d: 0};
        vt[8] = '{h: 639,  v: 1'b0, d: 0};
        vt[9] = '{h: 1023, v: 1'b0, d: 0};

        for (int n = 0; n < 1024; n++) mem[n] = 16'(n);
        reset_n = 1'b0;
        line_start = 1'b0;
        line_num = '0;
        sprite_x = 10'd200;
        sprite_y = 10'd100;
        hcount = '0;
`ifdef SPRITE_FETCH_HFLIP_EN
        hflip = 1'b1;
`endif

        // Reset state
        tick();
        tick();
        check("reset busy", 32'(fetch_busy), 0);
        check("reset done", 32'(fetch_done), 0);
        check("reset cs", 32'(rom_chipselect), 0);
        check("reset clken", 32'(rom_clken), 0);
        check("reset addr", 32'(rom_address), 0);
        check("reset pix", {pix_valid, pix_data}, 0);
        reset_n = 1'b1;
        tick();
        check("idle busy", 32'(fetch_busy), 0);

        // Test 1: row 5 fetch, addresses 160..191, done 34 cycles after line_start
        pulse(105);
        check("t1 check busy", 32'(fetch_busy), 1);
        check("t1 check cs", 32'(rom_chipselect), 0);
        for (int k = 0; k < W; k++) begin
            tick();
            check("t1 fetch cs", 32'(rom_chipselect), 1);
            check("t1 fetch addr", 32'(rom_address), 160 + k);
            check("t1 fetch done", 32'(fetch_done), 0);
        end
        tick();
        check("t1 drain cs", 32'(rom_chipselect), 0);
        check("t1 drain clken", 32'(rom_clken), 1);
        check("t1 drain busy", 32'(fetch_busy), 1);
        check("t1 drain done", 32'(fetch_done), 0);
        tick();
        check("t1 done pulse", 32'(fetch_done), 1);
        check("t1 done busy", 32'(fetch_busy), 0);
        check("t1 done clken", 32'(rom_clken), 0);
        tick();
        check("t1 done single", 32'(fetch_done), 0);

        // Test 2: swap in the filled row (next fetch misses), table then full sweep
        pulse(0);
        for (int i = 0; i < 10; i++) begin
            hcount = 10'(vt[i].h);
            tick();
            check("t2 vec valid", 32'(pix_valid), 32'(vt[i].v));
            check("t2 vec data", 32'(pix_data), 32'(vt[i].d));
        end
        for (int h = 0; h < 640; h++) begin
            hcount = 10'(h);
            tick();
            check("t2 sweep", {pix_valid, pix_data}, model(h, 200, 160));
        end

        // Test 3: rows -1 and 32 are out of range: no reads, quick done, empty line
        pulse(99);
        check("t3a busy", 32'(fetch_busy), 1);
        tick();
        check("t3a done", 32'(fetch_done), 1);
        check("t3a cs", 32'(rom_chipselect), 0);
        check("t3a busy end", 32'(fetch_busy), 0);
        pulse(132);
        check("t3b cs", 32'(rom_chipselect), 0);
        tick();
        check("t3b done", 32'(fetch_done), 1);
        check("t3b cs end", 32'(rom_chipselect), 0);
        for (int h = 190; h < 240; h++) begin
            hcount = 10'(h);
            tick();
            check("t3 empty line", {pix_valid, pix_data}, 0);
        end

        // Test 4: word 165 is the key colour
        mem[165] = 16'h0000;
        pulse(105);
        wait_done(40, cyc);
        check("t4 latency", 32'(cyc), 34);
        pulse(0);
        key_h = FLIP ? 226 : 205;
        hcount = 10'(key_h);
        tick();
        check("t4 key pixel", {pix_valid, pix_data}, 0);
        hcount = 10'(key_h - 1);
        tick();
        check("t4 left of key", {pix_valid, pix_data}, model(key_h - 1, 200, 160));
        check("t4 left valid", 32'(pix_valid), 1);
        hcount = 10'(key_h + 1);
        tick();
        check("t4 right of key", {pix_valid, pix_data}, model(key_h + 1, 200, 160));

        // Test 5: abort 10 cycles into FETCH
        hcount = 10'd210;
        pulse(105);
        tick();
        for (int k = 0; k < 10; k++) tick();
        check("t5 mid addr", 32'(rom_address), 170);
        pulse(105);
        check("t5 abort busy", 32'(fetch_busy), 1);
        check("t5 abort cs", 32'(rom_chipselect), 0);
        check("t5 abort done", 32'(fetch_done), 0);
        tick();
        check("t5 restart addr", 32'(rom_address), 160);
        check("t5 restart cs", 32'(rom_chipselect), 1);
        check("t5 aborted buf hidden", 32'(pix_valid), 0);
        wait_done(40, cyc);
        check("t5 restart latency", 32'(cyc), 33);
        pulse(0);
        tick();
        check("t5 refilled pix", {pix_valid, pix_data}, model(210, 200, 160));
        check("t5 refilled valid", 32'(pix_valid), 1);

        // Test 6: synchronous reset mid-FETCH
        pulse(105);
        for (int k = 0; k < 5; k++) tick();
        check("t6 pre cs", 32'(rom_chipselect), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6 busy", 32'(fetch_busy), 0);
        check("t6 done", 32'(fetch_done), 0);
        check("t6 cs", 32'(rom_chipselect), 0);
        check("t6 clken", 32'(rom_clken), 0);
        check("t6 addr", 32'(rom_address), 0);
        check("t6 pix", {pix_valid, pix_data}, 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (fetch_done || fetch_busy || rom_chipselect || pix_valid) seen++;
        end
        check("t6 stays idle", 32'(seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
